// File: rtl/bpf_packet_loader_pkg.sv
// Shared types and helpers for the BPF packet loader: FSM state encoding,
// last-word byte-count encoding and the packet length computation.
package bpf_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    DROP  = 2'd3
  } loader_state_t;

  // s_last_bytes value meaning "all four bytes of the last word are valid"
  localparam logic [1:0]  LAST_BYTES_FULL = 2'd0;
  localparam logic [31:0] BYTES_PER_WORD  = 32'd4;

  // Number of valid bytes carried by the final word of a packet
  function automatic logic [31:0] last_word_bytes(input logic [1:0] enc);
    return (enc == LAST_BYTES_FULL) ? BYTES_PER_WORD : {30'd0, enc};
  endfunction

  // Byte length of a packet of word_count words (word_count >= 1)
  function automatic logic [31:0] calc_packet_len(input logic [31:0] word_count,
                                                  input logic [1:0]  enc);
    return (word_count - 32'd1) * BYTES_PER_WORD + last_word_bytes(enc);
  endfunction

endpackage

// File: rtl/bpf_packet_loader_if.sv
// Bus bundle between the loader and its neighbours: snooper stream in,
// CPU packet-memory port, CPU completion handshake and verdict out.
interface bpf_packet_loader_if #(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2,
  parameter int PACKET_DATA_WIDTH      = 32,
  parameter int DROP_CNT_WIDTH         = 16
);
  // snooper stream
  logic [PACKET_DATA_WIDTH-1:0]      s_data;
  logic                              s_valid;
  logic                              s_last;
  logic [1:0]                        s_last_bytes;
  logic                              s_ready;
  // CPU packet memory
  logic                              packet_mem_rd_en;
  logic [PACKET_ADDR_WIDTH-1:0]      packet_addr;
  logic [PACKET_DATA_WIDTH-1:0]      packet_data;
  logic                              pkt_ready;
  logic [PACKET_BYTE_ADDR_WIDTH:0]   packet_len;
  // CPU completion and verdict
  logic                              cpu_done;
  logic                              cpu_accept;
  logic                              result_valid;
  logic                              result_accept;
  logic [PACKET_BYTE_ADDR_WIDTH:0]   result_len;
  logic [DROP_CNT_WIDTH-1:0]         drop_count;

  // Side feeding the loader (snooper + CPU)
  modport master (
    output s_data, s_valid, s_last, s_last_bytes,
    output packet_mem_rd_en, packet_addr, cpu_done, cpu_accept,
    input  s_ready, packet_data, pkt_ready, packet_len,
    input  result_valid, result_accept, result_len, drop_count
  );

  // The loader itself
  modport slave (
    input  s_data, s_valid, s_last, s_last_bytes,
    input  packet_mem_rd_en, packet_addr, cpu_done, cpu_accept,
    output s_ready, packet_data, pkt_ready, packet_len,
    output result_valid, result_accept, result_len, drop_count
  );
endinterface

// File: rtl/bpf_packet_loader_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port.
// The array itself has no reset so it maps onto block RAM; only the read
// data register is cleared.
module bpf_packet_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its value when no read is strobed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/bpf_packet_loader.sv
// Packet ingest stage ahead of the BPF CPU: fills the packet buffer from the
// snooper stream, exposes it to the CPU, reports the verdict, and drops
// packets larger than the buffer.
module bpf_packet_loader
  import bpf_loader_pkg::*;
#(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2,
  parameter int PACKET_DATA_WIDTH      = 32,
  parameter int DROP_CNT_WIDTH         = 16
) (
  input logic                clk,
  input logic                rst,
  bpf_packet_loader_if.slave bus
);
  localparam int LEN_WIDTH = PACKET_BYTE_ADDR_WIDTH + 1;
  // word count of a completely full buffer
  localparam logic [PACKET_ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {PACKET_ADDR_WIDTH{1'b0}}};

  loader_state_t                state_reg, state_next;
  logic [PACKET_ADDR_WIDTH:0]   wcnt_reg, wcnt_next;
  logic [LEN_WIDTH-1:0]         packet_len_reg, len_next;
  logic [LEN_WIDTH-1:0]         result_len_reg;
  logic                         result_valid_reg, result_accept_reg;
  logic [DROP_CNT_WIDTH-1:0]    drop_count_reg;

  logic                         s_ready;
  logic                         accept;
  logic                         mem_we;
  logic [PACKET_ADDR_WIDTH-1:0] mem_waddr;
  logic                         len_load;
  logic                         drop_inc;
  logic                         result_fire;

  // Handshake decode: never ready in reset, stall while the CPU owns the buffer
  assign s_ready = rst && (state_reg != READY);
  assign accept  = bus.s_valid && s_ready;

  // Length of the packet being closed, from the word count after this write
  assign len_next = LEN_WIDTH'(calc_packet_len(32'(wcnt_next), bus.s_last_bytes));

  // Next-state, buffer write and event decode
  always_comb begin
    state_next  = state_reg;
    wcnt_next   = wcnt_reg;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    len_load    = 1'b0;
    drop_inc    = 1'b0;
    result_fire = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wcnt_next = {{PACKET_ADDR_WIDTH{1'b0}}, 1'b1};
          if (bus.s_last) begin
            state_next = READY;
            len_load   = 1'b1;
          end else begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (wcnt_reg == DEPTH_CNT) begin
            // buffer already full: this packet is oversize
            if (bus.s_last) begin
              state_next = IDLE;
              drop_inc   = 1'b1;
            end else begin
              state_next = DROP;
            end
          end else begin
            mem_we    = 1'b1;
            mem_waddr = wcnt_reg[PACKET_ADDR_WIDTH-1:0];
            wcnt_next = wcnt_reg + 1'b1;
            if (bus.s_last) begin
              state_next = READY;
              len_load   = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (accept && bus.s_last) begin
          state_next = IDLE;
          drop_inc   = 1'b1;
        end
      end
      READY: begin
        if (bus.cpu_done) begin
          result_fire = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and word-count registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      wcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
    end
  end

  // Packet length captured when the final word is written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          packet_len_reg <= '0;
    else if (len_load) packet_len_reg <= len_next;
  end

  // Verdict registers: one-cycle valid pulse, payload held until the next verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_valid_reg  <= 1'b0;
      result_accept_reg <= 1'b0;
      result_len_reg    <= '0;
    end else begin
      result_valid_reg <= result_fire;
      if (result_fire) begin
        result_accept_reg <= bus.cpu_accept;
        result_len_reg    <= packet_len_reg;
      end
    end
  end

  // Saturating count of oversize packets
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_count_reg <= '0;
    else if (drop_inc && (drop_count_reg != {DROP_CNT_WIDTH{1'b1}}))
      drop_count_reg <= drop_count_reg + 1'b1;
  end

  bpf_packet_ram #(
    .ADDR_WIDTH (PACKET_ADDR_WIDTH),
    .DATA_WIDTH (PACKET_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (bus.s_data),
    .rd_en   (bus.packet_mem_rd_en),
    .rd_addr (bus.packet_addr),
    .rd_data (bus.packet_data)
  );

  assign bus.s_ready       = s_ready;
  assign bus.pkt_ready     = (state_reg == READY);
  assign bus.packet_len    = packet_len_reg;
  assign bus.result_valid  = result_valid_reg;
  assign bus.result_accept = result_accept_reg;
  assign bus.result_len    = result_len_reg;
  assign bus.drop_count    = drop_count_reg;
endmodule

// File: tb/tb_bpf_packet_loader.sv
// Self-checking bench for bpf_packet_loader: directed scenarios plus random
// packets, checked against a byte-level model of the packet buffer.
module tb_bpf_packet_loader;
  localparam int BAW = 12;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int DCW = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  // model: words of the packet currently being delivered
  logic [31:0] pkt_words[$];

  always #5 clk = ~clk;

  bpf_packet_loader_if #(.PACKET_BYTE_ADDR_WIDTH(BAW), .PACKET_ADDR_WIDTH(AW),
                         .PACKET_DATA_WIDTH(DW), .DROP_CNT_WIDTH(DCW)) bus ();

  bpf_packet_loader #(.PACKET_BYTE_ADDR_WIDTH(BAW), .PACKET_ADDR_WIDTH(AW),
                      .PACKET_DATA_WIDTH(DW), .DROP_CNT_WIDTH(DCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // expected byte length: full words minus the unused tail bytes of the last word
  function automatic int exp_len(input int nwords, input int lb);
    return nwords * 4 - ((lb == 0) ? 0 : (4 - lb));
  endfunction

  task automatic idle_inputs();
    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_last_bytes = 2'd0;
    bus.packet_mem_rd_en = 1'b0; bus.packet_addr = '0;
    bus.cpu_done = 1'b0; bus.cpu_accept = 1'b0;
  endtask

  // drive n consecutive words (one per cycle); counts cycles where s_ready was low
  task automatic send_words(input int n, input bit start, input bit end_pkt,
                            input logic [1:0] lb, output int ready_low);
    logic [31:0] w;
    ready_low = 0;
    if (start) pkt_words.delete();
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      pkt_words.push_back(w);
      bus.s_data = w; bus.s_valid = 1'b1;
      bus.s_last = end_pkt && (i == n - 1);
      bus.s_last_bytes = lb;
      if (bus.s_ready !== 1'b1) ready_low++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_last_bytes = 2'd0;
  endtask

  task automatic pulse_done(input logic acc);
    bus.cpu_done = 1'b1; bus.cpu_accept = acc;
    @(posedge clk); #1;
    bus.cpu_done = 1'b0; bus.cpu_accept = 1'b0;
  endtask

  task automatic read_word(input int addr);
    bus.packet_mem_rd_en = 1'b1; bus.packet_addr = AW'(addr);
    @(posedge clk); #1;
    bus.packet_mem_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
    checks++; if (bus.pkt_ready !== 1'b0) begin failures++; $display("FAIL reset_pkt_ready: got %b expected 0", bus.pkt_ready); end
    checks++; if (bus.packet_data !== 32'd0) begin failures++; $display("FAIL reset_packet_data: got %h expected 0", bus.packet_data); end
    checks++; if (bus.packet_len !== 13'd0 || bus.result_len !== 13'd0) begin failures++; $display("FAIL reset_len: got %0d/%0d expected 0/0", bus.packet_len, bus.result_len); end
    checks++; if (bus.result_valid !== 1'b0 || bus.result_accept !== 1'b0) begin failures++; $display("FAIL reset_result: got %b%b expected 00", bus.result_valid, bus.result_accept); end
    checks++; if (bus.drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop_count: got %0d expected 0", bus.drop_count); end
    rst = 1'b1;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_release_s_ready: got %b expected 1", bus.s_ready); end
    $display("test_reset done");
  endtask

  task automatic test_small_packet();
    int low;
    send_words(3, 1'b1, 1'b1, 2'd2, low);
    checks++; if (bus.pkt_ready !== 1'b1 || bus.s_ready !== 1'b0) begin failures++; $display("FAIL small_ready: got pkt_ready=%b s_ready=%b expected 1/0", bus.pkt_ready, bus.s_ready); end
    checks++; if (bus.packet_len !== 13'(exp_len(3, 2))) begin failures++; $display("FAIL small_len: got %0d expected %0d", bus.packet_len, exp_len(3, 2)); end
    for (int a = 0; a < 3; a++) begin
      read_word(a);
      checks++; if (bus.packet_data !== pkt_words[a]) begin failures++; $display("FAIL small_read%0d: got %h expected %h", a, bus.packet_data, pkt_words[a]); end
    end
    @(posedge clk); #1;
    checks++; if (bus.packet_data !== pkt_words[2]) begin failures++; $display("FAIL small_read_hold: got %h expected %h", bus.packet_data, pkt_words[2]); end
    pulse_done(1'b0);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_accept !== 1'b0 || bus.result_len !== 13'd10) begin failures++; $display("FAIL small_result: got v=%b a=%b len=%0d expected 1/0/10", bus.result_valid, bus.result_accept, bus.result_len); end
    checks++; if (bus.pkt_ready !== 1'b0 || bus.s_ready !== 1'b1) begin failures++; $display("FAIL small_release: got pkt_ready=%b s_ready=%b expected 0/1", bus.pkt_ready, bus.s_ready); end
    @(posedge clk); #1;
    checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL small_result_pulse: got %b expected 0", bus.result_valid); end
    $display("test_small_packet done len=%0d", exp_len(3, 2));
  endtask

  task automatic test_full_packet();
    int low;
    int addrs[8];
    send_words(DEPTH, 1'b1, 1'b1, 2'd0, low);
    checks++; if (low != 0) begin failures++; $display("FAIL full_s_ready_low: got %0d cycles expected 0", low); end
    checks++; if (bus.pkt_ready !== 1'b1 || bus.packet_len !== 13'(exp_len(DEPTH, 0))) begin failures++; $display("FAIL full_len: got pkt_ready=%b len=%0d expected 1/%0d", bus.pkt_ready, bus.packet_len, exp_len(DEPTH, 0)); end
    checks++; if (bus.drop_count !== 16'd0) begin failures++; $display("FAIL full_drop_count: got %0d expected 0", bus.drop_count); end
    addrs[0] = 0; addrs[1] = DEPTH - 1;
    for (int i = 2; i < 8; i++) addrs[i] = $urandom_range(DEPTH - 1, 0);
    for (int i = 0; i < 8; i++) begin
      read_word(addrs[i]);
      checks++; if (bus.packet_data !== pkt_words[addrs[i]]) begin failures++; $display("FAIL full_read@%0d: got %h expected %h", addrs[i], bus.packet_data, pkt_words[addrs[i]]); end
    end
    pulse_done(1'b1);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_accept !== 1'b1 || bus.result_len !== 13'd4096) begin failures++; $display("FAIL full_result: got v=%b a=%b len=%0d expected 1/1/4096", bus.result_valid, bus.result_accept, bus.result_len); end
    $display("test_full_packet done len=%0d", exp_len(DEPTH, 0));
  endtask

  task automatic test_oversize();
    int low;
    send_words(DEPTH + 1, 1'b1, 1'b1, 2'($urandom_range(3, 0)), low);
    checks++; if (low != 0) begin failures++; $display("FAIL over1025_s_ready_low: got %0d cycles expected 0", low); end
    checks++; if (bus.pkt_ready !== 1'b0 || bus.drop_count !== 16'd1) begin failures++; $display("FAIL over1025_drop: got pkt_ready=%b drop=%0d expected 0/1", bus.pkt_ready, bus.drop_count); end
    send_words(1, 1'b1, 1'b1, 2'd0, low);
    checks++; if (bus.pkt_ready !== 1'b1 || bus.packet_len !== 13'd4) begin failures++; $display("FAIL after_drop_len: got pkt_ready=%b len=%0d expected 1/4", bus.pkt_ready, bus.packet_len); end
    read_word(0);
    checks++; if (bus.packet_data !== pkt_words[0]) begin failures++; $display("FAIL after_drop_read: got %h expected %h", bus.packet_data, pkt_words[0]); end
    pulse_done(1'b1);
    send_words(DEPTH + 6, 1'b1, 1'b1, 2'd1, low);
    checks++; if (low != 0 || bus.pkt_ready !== 1'b0 || bus.drop_count !== 16'd2) begin failures++; $display("FAIL over1030_drop: got low=%0d pkt_ready=%b drop=%0d expected 0/0/2", low, bus.pkt_ready, bus.drop_count); end
    $display("test_oversize done drops=%0d", 2);
  endtask

  task automatic test_ready_hold();
    int low;
    int held_low;
    send_words(2, 1'b1, 1'b1, 2'd3, low);
    held_low = 0;
    bus.s_valid = 1'b1; bus.s_data = $urandom;
    for (int i = 0; i < 4; i++) begin
      if (bus.s_ready === 1'b0 && bus.pkt_ready === 1'b1) held_low++;
      @(posedge clk); #1;
    end
    checks++; if (held_low != 4) begin failures++; $display("FAIL hold_s_ready: got %0d stalled cycles expected 4", held_low); end
    checks++; if (bus.packet_len !== 13'(exp_len(2, 3))) begin failures++; $display("FAIL hold_len: got %0d expected %0d", bus.packet_len, exp_len(2, 3)); end
    pulse_done(1'b1);
    checks++; if (bus.result_valid !== 1'b1 || bus.result_accept !== 1'b1 || bus.result_len !== 13'(exp_len(2, 3))) begin failures++; $display("FAIL hold_result: got v=%b a=%b len=%0d expected 1/1/%0d", bus.result_valid, bus.result_accept, bus.result_len, exp_len(2, 3)); end
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL hold_s_ready_after_done: got %b expected 1", bus.s_ready); end
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL hold_result_pulse: got %b expected 0", bus.result_valid); end
    $display("test_ready_hold done len=%0d", exp_len(2, 3));
  endtask

  task automatic test_reset_mid_packet();
    int low;
    send_words(5, 1'b1, 1'b0, 2'd0, low);
    read_word(1);
    rst = 1'b0;
    #2;
    checks++; if (bus.s_ready !== 1'b0 || bus.pkt_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready: got s_ready=%b pkt_ready=%b expected 0/0", bus.s_ready, bus.pkt_ready); end
    checks++; if (bus.packet_len !== 13'd0 || bus.packet_data !== 32'd0 || bus.drop_count !== 16'd0) begin failures++; $display("FAIL midrst_values: got len=%0d data=%h drop=%0d expected 0/0/0", bus.packet_len, bus.packet_data, bus.drop_count); end
    checks++; if (bus.result_valid !== 1'b0 || bus.result_accept !== 1'b0 || bus.result_len !== 13'd0) begin failures++; $display("FAIL midrst_result: got v=%b a=%b len=%0d expected 0/0/0", bus.result_valid, bus.result_accept, bus.result_len); end
    @(posedge clk); #1;
    rst = 1'b1;
    send_words(5, 1'b1, 1'b1, 2'd0, low);
    checks++; if (bus.pkt_ready !== 1'b1 || bus.packet_len !== 13'd20) begin failures++; $display("FAIL midrst_new_len: got pkt_ready=%b len=%0d expected 1/20", bus.pkt_ready, bus.packet_len); end
    read_word(0);
    checks++; if (bus.packet_data !== pkt_words[0]) begin failures++; $display("FAIL midrst_read0: got %h expected %h", bus.packet_data, pkt_words[0]); end
    pulse_done(1'b0);
    $display("test_reset_mid_packet done len=%0d", 20);
  endtask

  task automatic test_done_ignored();
    int low;
    pulse_done(1'b1);
    checks++; if (bus.result_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.pkt_ready !== 1'b0) begin failures++; $display("FAIL done_idle: got v=%b s_ready=%b pkt_ready=%b expected 0/1/0", bus.result_valid, bus.s_ready, bus.pkt_ready); end
    send_words(2, 1'b1, 1'b0, 2'd0, low);
    pulse_done(1'b1);
    checks++; if (bus.result_valid !== 1'b0 || bus.s_ready !== 1'b1) begin failures++; $display("FAIL done_fill: got v=%b s_ready=%b expected 0/1", bus.result_valid, bus.s_ready); end
    send_words(1, 1'b0, 1'b1, 2'd1, low);
    checks++; if (bus.pkt_ready !== 1'b1 || bus.packet_len !== 13'(exp_len(3, 1))) begin failures++; $display("FAIL done_fill_continue: got pkt_ready=%b len=%0d expected 1/%0d", bus.pkt_ready, bus.packet_len, exp_len(3, 1)); end
    read_word(2);
    checks++; if (bus.packet_data !== pkt_words[2]) begin failures++; $display("FAIL done_fill_read2: got %h expected %h", bus.packet_data, pkt_words[2]); end
    pulse_done(1'b1);
    $display("test_done_ignored done len=%0d", exp_len(3, 1));
  endtask

  task automatic test_random_packets();
    int low, n, lb, a;
    logic acc;
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(40, 1);
      lb = $urandom_range(3, 0);
      acc = 1'($urandom_range(1, 0));
      send_words(n, 1'b1, 1'b1, 2'(lb), low);
      checks++; if (bus.pkt_ready !== 1'b1 || bus.packet_len !== 13'(exp_len(n, lb))) begin failures++; $display("FAIL rand%0d_len: got pkt_ready=%b len=%0d expected 1/%0d", p, bus.pkt_ready, bus.packet_len, exp_len(n, lb)); end
      for (int r = 0; r < 3; r++) begin
        a = $urandom_range(n - 1, 0);
        read_word(a);
        checks++; if (bus.packet_data !== pkt_words[a]) begin failures++; $display("FAIL rand%0d_read@%0d: got %h expected %h", p, a, bus.packet_data, pkt_words[a]); end
      end
      pulse_done(acc);
      checks++; if (bus.result_valid !== 1'b1 || bus.result_accept !== acc || bus.result_len !== 13'(exp_len(n, lb))) begin failures++; $display("FAIL rand%0d_result: got v=%b a=%b len=%0d expected 1/%b/%0d", p, bus.result_valid, bus.result_accept, bus.result_len, acc, exp_len(n, lb)); end
      $display("random packet %0d words=%0d last_bytes=%0d len=%0d accept=%b", p, n, lb, exp_len(n, lb), acc);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_small_packet();
    test_full_packet();
    test_oversize();
    test_ready_hold();
    test_reset_mid_packet();
    test_done_ignored();
    test_random_packets();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
